regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bundle: requester handshake, register-file write port, scoreboard set/query.
// Latency: none; this file only groups wires.
// Backpressure: req_ready is a one-hot grant; a requester holds valid/rd/data until it sees ready.
interface regfile_wb_arbiter_if #(
   parameter int XLEN = 32,
   parameter int NREQ = 3
);
   logic [NREQ-1:0]      req_valid;
   logic [5*NREQ-1:0]    req_rd;
   logic [XLEN*NREQ-1:0] req_data;
   logic [NREQ-1:0]      req_ready;

   logic                 wb_we;
   logic [4:0]           wb_rd;
   logic [XLEN-1:0]      wb_wdata;

   logic                 sb_set;
   logic [4:0]           sb_set_rd;
   logic                 flush;
   logic [4:0]           rs1;
   logic [4:0]           rs2;
   logic                 rs1_busy;
   logic                 rs2_busy;

   // Pipeline side: requesters, issue and decode stages.
   modport master (
      output req_valid, req_rd, req_data, sb_set, sb_set_rd, flush, rs1, rs2,
      input  req_ready, wb_we, wb_rd, wb_wdata, rs1_busy, rs2_busy
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_rd, req_data, sb_set, sb_set_rd, flush, rs1, rs2,
      output req_ready, wb_we, wb_rd, wb_wdata, rs1_busy, rs2_busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter into the register file plus a pending-write scoreboard.
// Latency: 1 cycle from accept (valid & ready) to wb_we; busy lookup is combinational.
// Backpressure: no internal queue; losers see ready low and must hold their request stable.
module regfile_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int NREQ = 3
) (
   input logic                clk,
   input logic                rst_n,
   regfile_wb_arbiter_if.slave bus
);

   localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [LGW-1:0] LAST_RST = LGW'(NREQ - 1);

   logic [LGW-1:0]  last_grant_q, last_grant_d;
   logic            wb_we_q, wb_we_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_wdata_q, wb_wdata_d;
   logic [31:0]     busy_q, busy_d;

   logic [NREQ-1:0] grant;
   logic            gnt_any;
   logic [LGW-1:0]  gnt_idx;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            set_eff;

   // Candidate index 'off' positions after the last winner, wrapping at NREQ.
   function automatic logic [LGW-1:0] rr_idx(input logic [LGW-1:0] last, input int off);
      return LGW'((int'(last) + off) % NREQ);
   endfunction

   // Round-robin search starting just after the previous winner; first valid requester wins.
   always_comb begin
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int off = 1; off <= NREQ; off++) begin
         if (!gnt_any && bus.req_valid[rr_idx(last_grant_q, off)]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_idx(last_grant_q, off);
         end
      end
      if (gnt_any) begin
         grant[gnt_idx] = 1'b1;
      end
   end

   // Winner's payload and next state of the write port; rd=0 is accepted but never written.
   always_comb begin
      sel_rd       = bus.req_rd[5*int'(gnt_idx) +: 5];
      sel_data     = bus.req_data[XLEN*int'(gnt_idx) +: XLEN];
      wb_we_d      = gnt_any && (sel_rd != 5'd0);
      wb_rd_d      = gnt_any ? sel_rd : wb_rd_q;
      wb_wdata_d   = gnt_any ? sel_data : wb_wdata_q;
      last_grant_d = gnt_any ? gnt_idx : last_grant_q;
   end

   // Scoreboard update: commit clears, issue sets (set wins), flush clears everything; x0 never busy.
   always_comb begin
      set_eff = bus.sb_set && (bus.sb_set_rd != 5'd0) && !bus.flush;
      busy_d  = busy_q;
      if (wb_we_q) begin
         busy_d[wb_rd_q] = 1'b0;
      end
      if (bus.sb_set && (bus.sb_set_rd != 5'd0)) begin
         busy_d[bus.sb_set_rd] = 1'b1;
      end
      if (bus.flush) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   // Busy lookup with commit bypass: a register being written this cycle reads free unless re-set now.
   always_comb begin
      bus.rs1_busy = (bus.rs1 != 5'd0) && busy_q[bus.rs1] &&
                     !(wb_we_q && (wb_rd_q == bus.rs1) && !(set_eff && (bus.sb_set_rd == bus.rs1)));
      bus.rs2_busy = (bus.rs2 != 5'd0) && busy_q[bus.rs2] &&
                     !(wb_we_q && (wb_rd_q == bus.rs2) && !(set_eff && (bus.sb_set_rd == bus.rs2)));
   end

   // All state; reset drops any in-flight write and points the pointer so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= LAST_RST;
         wb_we_q      <= 1'b0;
         wb_rd_q      <= 5'd0;
         wb_wdata_q   <= '0;
         busy_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wb_we_q      <= wb_we_d;
         wb_rd_q      <= wb_rd_d;
         wb_wdata_q   <= wb_wdata_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.req_ready = grant;
   assign bus.wb_we     = wb_we_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.wb_wdata  = wb_wdata_q;

endmodule
